// File: rtl/multicycle_alu.sv
// Multicycle ALU: registered result, Start/Busy/Done handshake,
// half/full width, iterative shifts and multiply. Option: FAST_SHIFT_EN.
module multicycle_alu #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FunSel,
    input  logic             WF,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut
);

    localparam int unsigned HW = WIDTH / 2;
    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = SW + 1;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic                   done_q;
    logic [WIDTH-1:0]       res_q;
    logic [3:0]             flags_q;
    logic [3:0]             op_q;
    logic                   half_q;
    logic                   wf_q;
    logic [CW-1:0]          cnt_q;
    logic [WIDTH-1:0]       x_q;
    logic                   c_q;
    logic [2*WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]       mplier_q;
    logic [2*WIDTH-1:0]     acc_q;

    function automatic logic [WIDTH-1:0] mask_of(input logic half);
        return half ? {{HW{1'b0}}, {HW{1'b1}}} : {WIDTH{1'b1}};
    endfunction

    function automatic logic msb_of(input logic [WIDTH-1:0] x,
                                    input logic half);
        return half ? x[HW-1] : x[WIDTH-1];
    endfunction

    // One-bit shift step; returns {carry_out, value}
    function automatic logic [WIDTH:0] shstep(input logic [WIDTH-1:0] x,
                                              input logic c,
                                              input logic [3:0] f,
                                              input logic half);
        logic [WIDTH-1:0] mk;
        logic [WIDTH-1:0] tb;
        logic             m;
        mk = mask_of(half);
        tb = mk ^ (mk >> 1);
        m  = msb_of(x, half);
        case (f)
            4'b1011: return {m, (x << 1) & mk};
            4'b1100: return {x[0], x >> 1};
            4'b1101: return {x[0], (x >> 1) | (m ? tb : '0)};
            4'b1110: return {m, ((x << 1) | {{(WIDTH-1){1'b0}}, c}) & mk};
            default: return {c, x};
        endcase
    endfunction

    function automatic logic [3:0] flags_of(input logic [3:0] old,
                                            input logic [WIDTH-1:0] r,
                                            input logic half,
                                            input logic cv,
                                            input logic cwe,
                                            input logic ov,
                                            input logic owe);
        return {r == '0, cwe ? cv : old[2], msb_of(r, half),
                owe ? ov : old[0]};
    endfunction

    logic             half_i;
    logic [3:0]       f_i;
    logic [WIDTH-1:0] mask_i;
    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] b_m;
    logic [SW-1:0]    n_i;
    logic             is_sh;
    logic             is_mul;
    logic             go_iter;

    assign half_i = ~FunSel[4];
    assign f_i    = FunSel[3:0];
    assign mask_i = mask_of(half_i);
    assign a_m    = A & mask_i;
    assign b_m    = B & mask_i;
    assign n_i    = B[SW-1:0];
    assign is_sh  = (f_i >= 4'b1011) && (f_i <= 4'b1110);
    assign is_mul = (f_i == 4'b1111);

    logic [WIDTH-1:0] op2;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] add_r;
    logic             add_c;
    logic             add_o;

    assign op2   = (f_i == 4'b0110) ? (~b_m & mask_i) : b_m;
    assign cin   = (f_i == 4'b0110) ? 1'b1 :
                   (f_i == 4'b0101) ? flags_q[2] : 1'b0;
    assign sum   = {1'b0, a_m} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};
    assign add_r = sum[WIDTH-1:0] & mask_i;
    assign add_c = half_i ? sum[HW] : sum[WIDTH];
    assign add_o = (msb_of(a_m, half_i) == msb_of(op2, half_i)) &&
                   (msb_of(add_r, half_i) != msb_of(a_m, half_i));

    logic [WIDTH-1:0] bx;
    logic             bc;

`ifdef FAST_SHIFT_EN
    // Barrel shifter: unrolled single-bit steps, identical to iterative path
    always_comb begin
        bx = a_m;
        bc = flags_q[2];
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(n_i)) begin
                {bc, bx} = shstep(bx, bc, f_i, half_i);
            end
        end
    end
    assign go_iter = is_mul;
`else
    assign bx      = a_m;
    assign bc      = flags_q[2];
    assign go_iter = is_mul || (is_sh && (n_i != '0));
`endif

    logic [WIDTH-1:0] r1;
    logic             c1;
    logic             o1;
    logic             cwe1;
    logic             owe1;

    // Single-cycle result and flag candidates for the operation being accepted
    always_comb begin
        r1   = '0;
        c1   = 1'b0;
        o1   = 1'b0;
        cwe1 = 1'b0;
        owe1 = 1'b0;
        case (f_i)
            4'b0000: r1 = a_m;
            4'b0001: r1 = b_m;
            4'b0010: r1 = ~a_m & mask_i;
            4'b0011: r1 = ~b_m & mask_i;
            4'b0100, 4'b0101, 4'b0110: begin
                r1   = add_r;
                c1   = add_c;
                o1   = add_o;
                cwe1 = 1'b1;
                owe1 = 1'b1;
            end
            4'b0111: r1 = a_m & b_m;
            4'b1000: r1 = a_m | b_m;
            4'b1001: r1 = a_m ^ b_m;
            4'b1010: r1 = ~(a_m & b_m) & mask_i;
            4'b1011, 4'b1100, 4'b1101, 4'b1110: begin
                r1   = bx;
                c1   = bc;
                cwe1 = 1'b1;
            end
            default: r1 = '0;
        endcase
    end

    logic [WIDTH-1:0]   sh_x;
    logic               sh_c;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   imask;
    logic [WIDTH-1:0]   it_r;
    logic               it_c;

    assign {sh_c, sh_x} = shstep(x_q, c_q, op_q, half_q);
    assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign imask  = mask_of(half_q);
    assign it_r   = (op_q == 4'b1111) ? (acc_nx[WIDTH-1:0] & imask) : sh_x;
    assign it_c   = (op_q == 4'b1111) ?
                    |(acc_nx & ~{{WIDTH{1'b0}}, imask}) : sh_c;

    // Control FSM with registered handshake, result and flags
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
            flags_q  <= FLAGS_RST;
            op_q     <= '0;
            half_q   <= 1'b0;
            wf_q     <= 1'b0;
            cnt_q    <= '0;
            x_q      <= '0;
            c_q      <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (Start) begin
                        op_q   <= f_i;
                        half_q <= half_i;
                        wf_q   <= WF;
                        if (go_iter) begin
                            state_q  <= ITER;
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                            cnt_q    <= is_mul ?
                                        (half_i ? CW'(HW) : CW'(WIDTH)) :
                                        CW'(n_i);
                            x_q      <= a_m;
                            c_q      <= flags_q[2];
                            mcand_q  <= {{WIDTH{1'b0}}, a_m};
                            mplier_q <= b_m;
                            acc_q    <= '0;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            res_q   <= r1;
                            if (WF) begin
                                flags_q <= flags_of(flags_q, r1, half_i,
                                                    c1, cwe1, o1, owe1);
                            end
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ITER: begin
                    x_q      <= sh_x;
                    c_q      <= sh_c;
                    acc_q    <= acc_nx;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        res_q   <= it_r;
                        if (wf_q) begin
                            flags_q <= flags_of(flags_q, it_r, half_q,
                                                it_c, 1'b1, 1'b0, 1'b0);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign ALUOut   = res_q;
    assign FlagsOut = flags_q;

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, handshaked successor to the datapath's single-cycle ALU; sits between the register-file operand muxes and the writeback mux.
- Adds registered results, a Start/Busy/Done handshake, half/full width mode, multi-bit shifts by B, and an iterative unsigned multiply.
- Flags register {Z,C,N,O} is held inside the block.

Parameters:
- WIDTH, 32, datapath width; must be even and >= 8.
- FLAGS_RST, 4'b0000, FlagsOut value after reset.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  request; accepted only when Busy=0
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B; low $clog2(WIDTH) bits give the shift amount
- FunSel  in  5  [4]=width select (1 full, 0 half), [3:0]=operation
- WF  in  1  write flags for this operation
- Busy  out  1  iterative operation in progress
- Done  out  1  one-cycle pulse; ALUOut valid
- ALUOut  out  WIDTH  registered result, held until the next Done
- FlagsOut  out  4  {Z,C,N,O}, registered

Behaviour:
- Reset: state IDLE; Busy=0, Done=0, ALUOut=0, FlagsOut=FLAGS_RST. Reset mid-operation aborts it; no flags or result are written.
- Acceptance: on the first edge with Start=1 and Busy=0, A, B, FunSel and WF are latched. Start while Busy=1 is ignored. Start in the Done cycle is accepted (back-to-back operation).
- Half mode: operands are the low WIDTH/2 bits. ALUOut upper half is 0. Flags are computed on WIDTH/2 bits, with the MSB at bit WIDTH/2-1.
- Operations (f = FunSel[3:0]):
  - 0000 A
  - 0001 B
  - 0010 ~A
  - 0011 ~B
  - 0100 A+B
  - 0101 A+B+C
  - 0110 A-B
  - 0111 AND
  - 1000 OR
  - 1001 XOR
  - 1010 NAND
  - 1011 LSL by n
  - 1100 LSR by n
  - 1101 ASR by n
  - 1110 rotate left through C by n
  - 1111 unsigned MUL, low half of the product
- Shift amount n = B[$clog2(WIDTH)-1:0]. In half mode an n >= WIDTH/2 is legal and shifts everything out.
- FSM states: IDLE, ITER, DONE.
  - IDLE/DONE --Start, f<=1010--> DONE: 1-cycle latency.
  - IDLE/DONE --Start, shift op with n=0--> DONE: result = A, C unchanged.
  - IDLE/DONE --Start, shift op with n>0--> ITER: one bit per cycle, n cycles, then DONE. Latency n+1.
  - IDLE/DONE --Start, MUL--> ITER: shift-add, one multiplier bit per cycle, W cycles (W = active width), then DONE. Latency W+1.
  - DONE --no Start--> IDLE.
- Busy=1 exactly while in ITER. Done=1 exactly while in DONE. ALUOut updates on entry to DONE.
- Flags update on entry to DONE, only if the latched WF=1:
  - Z: result==0.
  - N: result MSB.
  - C: carry-out for add/addc; no-borrow (A>=B unsigned) for sub; last bit shifted out for shifts/rotate; 1 if the discarded high product half is nonzero for MUL; unchanged for f<=0011 and logic ops.
  - O: signed overflow for add/addc/sub; unchanged for all other ops.
- ADDC and rotate use the C held in FlagsOut when Start is accepted.

Optional Feature:
- Macro FAST_SHIFT_EN.
- Defined: shifts and rotate use a barrel shifter and take the 1-cycle path regardless of n; result and flags are identical to the iterative path. MUL stays iterative.
- Undefined: iterative shifting as specified above.

Test Plan:
- Reset; WIDTH=32; A=5, B=7, FunSel=10100, WF=1, Start pulse -> next cycle Done=1, ALUOut=12, FlagsOut=0000, Busy never 1.
- A=0x7FFFFFFF, B=1, FunSel=10100, WF=1 -> ALUOut=0x80000000, FlagsOut=0011 (N,O). Repeat with WF=0 -> flags held at 0011.
- A=0x80000001, B=4, FunSel=11100 -> Busy high 4 cycles, Done on cycle 5, ALUOut=0x08000000, C=0 (last bit out was 0). With FAST_SHIFT_EN -> Done on cycle 1, same values.
- A=0x00010000, B=0x00010000, FunSel=11111, WF=1 -> Done after 33 cycles, ALUOut=0, FlagsOut=1100. Start pulses during Busy are ignored.
- Half mode: A=3, B=5, FunSel=00110, WF=1 -> ALUOut=0x0000FFFE, FlagsOut=0010.
- Reset asserted mid-MUL (cycle 10) -> next cycle Busy=0, Done=0, ALUOut=0, FlagsOut=FLAGS_RST; no Done pulse follows.
